// File: rtl/bcd_pkg.sv
// Shared BCD types and elaboration-time helpers for the binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

    // Decimal digits needed to hold 2**bin_w-1 (log10(2) ~= 0.301).
    function automatic int full_digits(input int bin_w);
        return (bin_w * 301) / 1000 + 1;
    endfunction

    function automatic int unsigned pow10(input int d);
        int unsigned r;
        r = 32'd1;
        for (int i = 0; i < d; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    // Pre-shift correction so the following left shift yields a valid BCD digit
    always_comb begin
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bin2bcd_serial.sv
// Iterative shift-add-3 binary-to-BCD converter, one shift per clock, valid/ready on both sides.
// Optional feature macro: BIN2BCD_OVF_SAT_EN saturates out_bcd_o to all-9s on overflow.
module bin2bcd_serial
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [BIN_W-1:0]      in_bin_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4*DIGITS-1:0]   out_bcd_o,
    output logic                  out_ovf_o
);

    localparam int FULL_D = full_digits(BIN_W);
    localparam int BCD_W  = 4 * FULL_D;
    localparam int REG_W  = BCD_W + BIN_W;
    localparam int OUT_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [31:0]      OVF_LIM  = 32'(pow10(DIGITS) - 32'd1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);

    b2b_state_t        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_bcd_q, out_bcd_d;
    logic              out_ovf_q, out_ovf_d;

    logic [BCD_W-1:0]  adj_s;
    logic [REG_W-1:0]  shift_s;
    logic [BCD_W-1:0]  new_bcd_s;
    logic [OUT_W-1:0]  trunc_s;

    for (genvar g = 0; g < FULL_D; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_i (bcd_q[4*g +: 4]),
            .digit_o (adj_s[4*g +: 4])
        );
    end

    assign shift_s   = {adj_s, bin_q} << 1;
    assign new_bcd_s = shift_s[REG_W-1:BIN_W];
    assign trunc_s   = OUT_W'(new_bcd_s);

    // Next-state, datapath and output-register update for the IDLE/SHIFT/DONE sequence
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_bcd_d   = out_bcd_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    bcd_d      = '0;
                    bin_d      = in_bin_i;
                    count_d    = CNT_LOAD;
                    ovf_d      = (32'(in_bin_i) > OVF_LIM);
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            SHIFT: begin
                bcd_d = new_bcd_s;
                bin_d = shift_s[BIN_W-1:0];
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    count_d = count_q;
                end
                // The result register is loaded from the final shift, not from bcd_q
                if (count_q <= CNT_W'(1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_ovf_d   = ovf_q;
`ifdef BIN2BCD_OVF_SAT_EN
                    if (ovf_q) begin
                        out_bcd_d = {DIGITS{4'h9}};
                    end else begin
                        out_bcd_d = trunc_s;
                    end
`else
                    out_bcd_d = trunc_s;
`endif
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            bcd_q       <= '0;
            bin_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_bcd_o   = out_bcd_q;
    assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Self-checking bench for bin2bcd_serial (BIN_W=7, DIGITS=2); build with and without BIN2BCD_OVF_SAT_EN.
module tb_bin2bcd_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_bcd;
    logic       out_ovf;

    int errors = 0;
    int checks = 0;

    bin2bcd_serial #(.BIN_W(7), .DIGITS(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_bin_i    (in_bin),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_bcd_o   (out_bcd),
        .out_ovf_o   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal arithmetic on the value, then pack two digits.
    task automatic model(input int v, output logic [7:0] eb, output logic eo);
        int m;
        eo = (v > 99);
        m  = v % 100;
        eb = {4'(m / 10), 4'(m % 10)};
`ifdef BIN2BCD_OVF_SAT_EN
        if (eo) eb = 8'h99;
`endif
    endtask

    task automatic run_conv(input int v, input string tag);
        logic [7:0] eb;
        logic       eo;
        int         n;
        model(v, eb, eo);
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_bin    = 7'(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        n = 1;
        while (!out_valid && n < 20) begin step(); n++; end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_bcd"}, 32'(out_bcd), 32'(eb));
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
        step();
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [7:0] eb;
        logic eo;
        rst = 1'b1; in_valid = 1'b0; in_bin = 7'd0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bcd", 32'(out_bcd), 32'h00);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);

        run_conv(57, "d57");
        run_conv(0, "d0");
        run_conv(99, "d99");
        run_conv(9, "d9");
        run_conv(127, "d127");
`ifdef BIN2BCD_OVF_SAT_EN
        chk("max_sat", 32'(out_bcd), 32'h99);
`else
        chk("max_trunc", 32'(out_bcd), 32'h27);
`endif
        chk("max_ovf", 32'(out_ovf), 32'd1);

        for (int v = 0; v < 100; v++) run_conv(v, "sweep");
        for (int i = 0; i < 30; i++) run_conv(int'($urandom_range(0, 127)), "rand");

        // Backpressure: hold result 42 while 13 is offered and must be ignored
        model(42, eb, eo);
        in_bin = 7'd42; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("bp_latency", 32'(n), 32'd8);
        for (int c = 0; c < 10; c++) begin
            in_bin   = 7'd13;
            in_valid = c[0];
            step();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_bcd", 32'(out_bcd), 32'(eb));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        n = 0;
        for (int c = 0; c < 12; c++) begin step(); n += int'(out_valid); end
        chk("bp_no_queue", 32'(n), 32'd0);
        run_conv(13, "d13");

        // Reset during the third SHIFT cycle of 88
        in_bin = 7'd88; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_bcd", 32'(out_bcd), 32'h00);
        chk("abort_out_ovf", 32'(out_ovf), 32'd0);
        n = 0;
        for (int c = 0; c < 12; c++) begin step(); n += int'(out_valid); end
        chk("abort_no_result", 32'(n), 32'd0);
        run_conv(42, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
